// File: rtl/clock_time_core.sv
// Timekeeping core: prescaled seconds/minutes/hours, time and alarm load, alarm ring FSM.
// Optional snooze state is built when CLOCK_SNOOZE_EN is defined.
module clock_time_core #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int MAX_MINUTES    = 60,
    parameter int MAX_HOURS      = 24,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(MAX_MINUTES)-1:0] minutes_settings,
    input  logic [$clog2(MAX_HOURS)-1:0]   hours_settings,
    input  logic                         set_time,
    input  logic                         set_alarm,
    input  logic                         alarm_enable,
    input  logic                         stop_btn,
    input  logic                         snooze_btn,
    output logic                         sec_tick,
    output logic [5:0]                   cur_seconds,
    output logic [$clog2(MAX_MINUTES):0]   cur_minutes,
    output logic [$clog2(MAX_HOURS):0]     cur_hours,
    output logic [$clog2(MAX_MINUTES)-1:0] cur_alarm_minutes,
    output logic [$clog2(MAX_HOURS)-1:0]   cur_alarm_hours,
    output logic                         alarm_ring
);
    // state   | meaning
    // IDLE    | alarm silent, waiting for a matching minute rollover
    // RINGING | alarm_ring high, ring timeout counting seconds
    // SNOOZE  | silenced, waiting for the snooze target rollover

    localparam int MW = $clog2(MAX_MINUTES);
    localparam int HW = $clog2(MAX_HOURS);
    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;

    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ_HZ - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [MW:0]   MIN_LIM = MAX_MINUTES[MW:0];
    localparam logic [MW:0]   MIN_MAX = MIN_LIM - MIN_LIM + (MIN_LIM - 1'b1);
    localparam logic [MW:0]   MIN_ONE = 1;
    localparam logic [HW:0]   HR_LIM = MAX_HOURS[HW:0];
    localparam logic [HW:0]   HR_MAX = HR_LIM - 1'b1;
    localparam logic [HW:0]   HR_ONE = 1;
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECONDS - 1);
    localparam logic [RW-1:0] RING_ONE = RW'(1);

`ifdef CLOCK_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RINGING} state_t;
`endif

    state_t        state_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [MW:0]   min_q, min_d, nm;
    logic [HW:0]   hr_q, hr_d, nh, nh_inc;
    logic [MW-1:0] al_min_q;
    logic [HW-1:0] al_hr_q;
    logic [RW-1:0] ring_cnt_q;
    logic          alarm_ring_q;
    logic          set_time_prev_q, set_alarm_prev_q, stop_prev_q;
    logic          tick, settings_ok, load_time, load_alarm, stop_fall;
    logic          sec_wrap, min_wrap, hr_wrap, rollover, alarm_hit;

    assign tick        = (presc_q == PRESC_TC);
    assign settings_ok = ({1'b0, minutes_settings} < MIN_LIM) && ({1'b0, hours_settings} < HR_LIM);
    assign load_time   = set_time & ~set_time_prev_q & settings_ok;
    assign load_alarm  = set_alarm & ~set_alarm_prev_q & settings_ok;
    assign stop_fall   = stop_prev_q & ~stop_btn;

    assign sec_wrap = (sec_q == 6'd59);
    assign min_wrap = (min_q == MIN_MAX);
    assign hr_wrap  = (hr_q == HR_MAX);
    assign nm       = min_wrap ? '0 : min_q + MIN_ONE;
    assign nh_inc   = hr_wrap ? '0 : hr_q + HR_ONE;
    assign nh       = min_wrap ? nh_inc : hr_q;

    // A load in the same cycle wins over the tick, so it can never trigger the alarm.
    assign rollover  = tick & sec_wrap & ~load_time;
    assign alarm_hit = rollover && (nm == {1'b0, al_min_q}) && (nh == {1'b0, al_hr_q});

    always_comb begin
        presc_d = tick ? '0 : presc_q + PRESC_ONE;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        if (load_time) begin
            presc_d = '0;
            sec_d   = '0;
            min_d   = {1'b0, minutes_settings};
            hr_d    = {1'b0, hours_settings};
        end else if (tick) begin
            sec_d = sec_wrap ? '0 : sec_q + 6'd1;
            if (sec_wrap) begin
                min_d = nm;
                hr_d  = nh;
            end
        end
    end

`ifdef CLOCK_SNOOZE_EN
    localparam logic [MW+1:0] SNZ_ADD = SNOOZE_MINUTES[MW+1:0];
    localparam logic [MW+1:0] SNZ_LIM = MAX_MINUTES[MW+1:0];

    logic          snooze_prev_q, snooze_fall, snooze_hit;
    logic [MW:0]   snz_min_q, snz_min_d;
    logic [HW:0]   snz_hr_q, snz_hr_d;
    logic [MW+1:0] snz_sum, snz_sub;

    assign snooze_fall = snooze_prev_q & ~snooze_btn;
    assign snz_sum     = {1'b0, min_q} + SNZ_ADD;
    assign snz_sub     = snz_sum - SNZ_LIM;
    assign snooze_hit  = rollover && (nm == snz_min_q) && (nh == snz_hr_q);

    always_comb begin
        snz_min_d = snz_sum[MW:0];
        snz_hr_d  = hr_q;
        if (snz_sum >= SNZ_LIM) begin
            snz_min_d = snz_sub[MW:0];
            snz_hr_d  = nh_inc;
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = snooze_btn | (SNOOZE_MINUTES == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q          <= '0;
            sec_q            <= '0;
            min_q            <= '0;
            hr_q             <= '0;
            al_min_q         <= '0;
            al_hr_q          <= '0;
            set_time_prev_q  <= 1'b0;
            set_alarm_prev_q <= 1'b0;
            stop_prev_q      <= 1'b1;
            state_q          <= IDLE;
            ring_cnt_q       <= '0;
            alarm_ring_q     <= 1'b0;
`ifdef CLOCK_SNOOZE_EN
            snooze_prev_q    <= 1'b1;
            snz_min_q        <= '0;
            snz_hr_q         <= '0;
`endif
        end else begin
            presc_q          <= presc_d;
            sec_q            <= sec_d;
            min_q            <= min_d;
            hr_q             <= hr_d;
            set_time_prev_q  <= set_time;
            set_alarm_prev_q <= set_alarm;
            stop_prev_q      <= stop_btn;
`ifdef CLOCK_SNOOZE_EN
            snooze_prev_q    <= snooze_btn;
`endif
            if (load_alarm) begin
                al_min_q <= minutes_settings;
                al_hr_q  <= hours_settings;
            end
            case (state_q)
                IDLE: begin
                    if (alarm_hit && alarm_enable) begin
                        state_q      <= RINGING;
                        ring_cnt_q   <= RING_LOAD;
                        alarm_ring_q <= 1'b1;
                    end
                end
                RINGING: begin
                    if (stop_fall || !alarm_enable) begin
                        state_q      <= IDLE;
                        alarm_ring_q <= 1'b0;
`ifdef CLOCK_SNOOZE_EN
                    end else if (snooze_fall) begin
                        state_q      <= SNOOZE;
                        alarm_ring_q <= 1'b0;
                        snz_min_q    <= snz_min_d;
                        snz_hr_q     <= snz_hr_d;
`endif
                    end else if (tick) begin
                        if (ring_cnt_q == '0) begin
                            state_q      <= IDLE;
                            alarm_ring_q <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q - RING_ONE;
                        end
                    end
                end
`ifdef CLOCK_SNOOZE_EN
                SNOOZE: begin
                    if (stop_fall || !alarm_enable) begin
                        state_q <= IDLE;
                    end else if (snooze_hit) begin
                        state_q      <= RINGING;
                        ring_cnt_q   <= RING_LOAD;
                        alarm_ring_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    alarm_ring_q <= 1'b0;
                end
            endcase
        end
    end

    assign sec_tick          = tick;
    assign cur_seconds       = sec_q;
    assign cur_minutes       = min_q;
    assign cur_hours         = hr_q;
    assign cur_alarm_minutes = al_min_q;
    assign cur_alarm_hours   = al_hr_q;
    assign alarm_ring        = alarm_ring_q;
endmodule
